// File: rtl/adder32_pkg.sv
// Shared types, constants and lookahead helpers for the adder32_cla datapath.
package adder32_pkg;

  localparam int ADD_WIDTH = 32;
  localparam int CLA_GROUP = 4;

  typedef logic [ADD_WIDTH-1:0] word_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } add_flags_t;

  // Group generate/propagate over four generate/propagate pairs: returns {G, P}.
  function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
    logic grp_g;
    logic grp_p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    return {grp_g, grp_p};
  endfunction

  // Carries into positions 1..3 of a four-wide group, flattened (no ripple).
  function automatic logic [2:0] inner_carries(input logic [3:0] g, input logic [3:0] p,
                                               input logic cin);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/adder32_cla_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate for the next level.
module cla4
  import adder32_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);

  logic [3:0] bit_g;
  logic [3:0] bit_p;
  logic [2:0] c;

  assign bit_g   = a & b;
  assign bit_p   = a ^ b;
  assign c       = inner_carries(bit_g, bit_p, cin);
  assign s       = bit_p ^ {c, cin};
  assign {g, p}  = group_gp(bit_g, bit_p);

endmodule

// File: rtl/adder32_cla.sv
// 32-bit two-level carry-lookahead adder with a registered sum.
// Define ADDER32_FLAGS_EN to add the cout/ovf/zero flags and their registered copy.
module adder32_cla
  import adder32_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_q
`ifdef ADDER32_FLAGS_EN
  ,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [2:0]       flags_q
`endif
);

  localparam int NSLICE = WIDTH / CLA_GROUP;
  localparam int NBLOCK = (NSLICE + 3) / 4;
  localparam int NPAD   = NBLOCK * 4;

  logic [NPAD-1:0] slice_g;
  logic [NPAD-1:0] slice_p;
  logic [NBLOCK-1:0] block_g;
  logic [NBLOCK-1:0] block_p;
  // carry[i] is the carry into slice i; carry[NSLICE] is the carry out of the MSB.
  logic [NPAD:0] carry;

  assign carry[0] = 1'b0;

  for (genvar s = 0; s < NPAD; s++) begin : g_slice
    if (s < NSLICE) begin : g_real
      cla4 u_cla4 (
        .a   (a[CLA_GROUP*s +: CLA_GROUP]),
        .b   (b[CLA_GROUP*s +: CLA_GROUP]),
        .cin (carry[s]),
        .s   (sum[CLA_GROUP*s +: CLA_GROUP]),
        .g   (slice_g[s]),
        .p   (slice_p[s])
      );
    end else begin : g_pad
      assign slice_g[s] = 1'b0;
      assign slice_p[s] = 1'b0;
    end
  end

  // Second lookahead level: each block of four slices yields its own G/P and
  // the slice carries inside it are formed directly from the block carry-in.
  for (genvar k = 0; k < NBLOCK; k++) begin : g_block
    assign {block_g[k], block_p[k]} = group_gp(slice_g[4*k +: 4], slice_p[4*k +: 4]);
    assign carry[4*k+3 -: 3] = inner_carries(slice_g[4*k +: 4], slice_p[4*k +: 4], carry[4*k]);
    assign carry[4*k+4]      = block_g[k] | (block_p[k] & carry[4*k]);
  end

`ifdef ADDER32_FLAGS_EN
  add_flags_t flags;

  assign flags.cout = carry[NSLICE];
  assign flags.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign flags.zero = ~|sum;
  assign cout       = flags.cout;
  assign ovf        = flags.ovf;
  assign zero       = flags.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags;
    end
  end
`else
  logic unused_carry_out;
  assign unused_carry_out = carry[NSLICE];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum;
    end
  end

endmodule

// File: tb/tb_adder32_cla.sv
// Bench for adder32_cla: directed vectors, registered path with async reset, random sweep.
module tb_adder32_cla;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic [31:0] sum_q;
`ifdef ADDER32_FLAGS_EN
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [2:0]  flags_q;
`endif

  int checks = 0;
  int errors = 0;

  adder32_cla dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .sum     (sum),
    .sum_q   (sum_q)
`ifdef ADDER32_FLAGS_EN
    ,
    .cout    (cout),
    .ovf     (ovf),
    .zero    (zero),
    .flags_q (flags_q)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    a = 32'h0;
    b = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sum_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_sum_q: got %h expected %h", sum_q, 32'h0);
    end
    a = 32'h1234_0000;
    b = 32'h0000_5678;
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold_sum_q: got %h expected %h", sum_q, 32'h0);
    end
    checks++;
    if (sum !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_sum_tracks: got %h expected %h", sum, 32'h1234_5678);
    end
`ifdef ADDER32_FLAGS_EN
    checks++;
    if (flags_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags_q: got %b expected %b", flags_q, 3'b000);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vs [6];
    logic [2:0]  vf [6];  // {cout, ovf, zero}
    va[0] = 32'hffff_ffff; vb[0] = 32'h0000_0001; vs[0] = 32'h0000_0000; vf[0] = 3'b101;
    va[1] = 32'hffff_ffff; vb[1] = 32'h0000_0000; vs[1] = 32'hffff_ffff; vf[1] = 3'b000;
    va[2] = 32'hbcda_bcda; vb[2] = 32'h7986_7986; vs[2] = 32'h3661_3660; vf[2] = 3'b100;
    va[3] = 32'h9657_9657; vb[3] = 32'h3456_3456; vs[3] = 32'hcaad_caad; vf[3] = 3'b000;
    va[4] = 32'h7fff_ffff; vb[4] = 32'h0000_0001; vs[4] = 32'h8000_0000; vf[4] = 3'b010;
    va[5] = 32'h8000_0000; vb[5] = 32'h8000_0000; vs[5] = 32'h0000_0000; vf[5] = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      #1;
      checks++;
      if (sum !== vs[i]) begin
        errors++;
        $display("FAIL directed_sum[%0d]: got %h expected %h", i, sum, vs[i]);
      end
`ifdef ADDER32_FLAGS_EN
      checks++;
      if ({cout, ovf, zero} !== vf[i]) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %b expected %b", i, {cout, ovf, zero}, vf[i]);
      end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== vs[i]) begin
        errors++;
        $display("FAIL directed_sum_q[%0d]: got %h expected %h", i, sum_q, vs[i]);
      end
`ifdef ADDER32_FLAGS_EN
      checks++;
      if (flags_q !== vf[i]) begin
        errors++;
        $display("FAIL directed_flags_q[%0d]: got %b expected %b", i, flags_q, vf[i]);
      end
`endif
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a = 32'h0000_0000;
    b = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    a = 32'h0000_0005;
    b = 32'h0000_0003;
    #1;
    checks++;
    if (sum_q !== 32'h0) begin
      errors++;
      $display("FAIL reg_before_edge: got %h expected %h", sum_q, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'h0000_0008) begin
      errors++;
      $display("FAIL reg_after_edge: got %h expected %h", sum_q, 32'h8);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sum_q !== 32'h0) begin
      errors++;
      $display("FAIL reg_async_reset: got %h expected %h", sum_q, 32'h0);
    end
    checks++;
    if (sum !== 32'h0000_0008) begin
      errors++;
      $display("FAIL reg_sum_in_reset: got %h expected %h", sum, 32'h8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sum_q !== 32'h0) begin
      errors++;
      $display("FAIL reg_release_no_capture: got %h expected %h", sum_q, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'h0000_0008) begin
      errors++;
      $display("FAIL reg_first_capture: got %h expected %h", sum_q, 32'h8);
    end
  endtask

  task automatic test_random();
    logic [32:0] full;
    logic [31:0] exp_sum;
    logic [2:0]  exp_flags;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      full = {1'b0, a} + {1'b0, b};
      exp_sum = full[31:0];
      exp_flags = {full[32], (a[31] == b[31]) && (exp_sum[31] != a[31]), exp_sum == 32'h0};
      #1;
      checks++;
      if (sum !== exp_sum) begin
        errors++;
        $display("FAIL random_sum[%0d]: a=%h b=%h got %h expected %h", i, a, b, sum, exp_sum);
      end
`ifdef ADDER32_FLAGS_EN
      checks++;
      if ({cout, ovf, zero} !== exp_flags) begin
        errors++;
        $display("FAIL random_flags[%0d]: got %b expected %b", i, {cout, ovf, zero}, exp_flags);
      end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== exp_sum) begin
        errors++;
        $display("FAIL random_sum_q[%0d]: got %h expected %h", i, sum_q, exp_sum);
      end
`ifdef ADDER32_FLAGS_EN
      checks++;
      if (flags_q !== exp_flags) begin
        errors++;
        $display("FAIL random_flags_q[%0d]: got %b expected %b", i, flags_q, exp_flags);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_registered();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
